// File: rtl/usb_fifo_byte_reader_pkg.sv
// Shared constants for the USB capture-FIFO byte reader: register map,
// control bit positions, the empty-buffer filler byte and the status byte layout.
package usb_fifo_byte_reader_pkg;

  localparam int         BYTECNT_SIZE    = 7;
  localparam logic [7:0] FIFO_ADDR       = 8'd3;
  localparam logic [7:0] CTRL_ADDR       = 8'd4;
  localparam int         CTRL_ENABLE_BIT = 0;
  localparam int         CTRL_FLUSH_BIT  = 1;
  localparam logic [7:0] UNDERFLOW_FILL  = 8'hEE;

  function automatic logic [7:0] status_byte(input logic uf, input logic [1:0] cnt,
                                             input logic en);
    return {4'b0000, uf, cnt, en};
  endfunction

endpackage

// File: rtl/usb_fifo_byte_reader_prefetch_buf.sv
// Two-entry 32-bit prefetch ring. Push and pop in the same cycle keep word order;
// a pop against an empty ring is reported and otherwise ignored.
module usb_fifo_byte_reader_prefetch_buf
  import usb_fifo_byte_reader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] head,
  output logic [1:0]  count,
  output logic        pop_empty
);

  logic [31:0] mem [2];
  logic        head_ptr;
  logic        tail_ptr;
  logic        pop_ok;

  assign pop_ok    = pop & (count != 2'd0);
  assign pop_empty = pop & (count == 2'd0);
  assign head      = mem[head_ptr];

  // Ring pointers and occupancy; flush and reset empty the ring in one cycle.
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) tail_ptr <= ~tail_ptr;
      else      tail_ptr <= tail_ptr;
      if (pop_ok) head_ptr <= ~head_ptr;
      else        head_ptr <= head_ptr;
      case ({push, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Word storage; a fill arriving during reset or flush is dropped.
  always_ff @(posedge clk) begin
    if (push & ~reset & ~flush) mem[tail_ptr] <= push_data;
  end

endmodule

// File: rtl/usb_fifo_byte_reader.sv
// Byte-wide reader of the 32-bit capture FIFO for the USB register bus, with a
// two-word prefetch, bus-hold request and a control/status register.
module usb_fifo_byte_reader
  import usb_fifo_byte_reader_pkg::*;
#(
  parameter int         pBYTECNT_SIZE = BYTECNT_SIZE,
  parameter logic [7:0] pFIFO_ADDR    = FIFO_ADDR,
  parameter logic [7:0] pCTRL_ADDR    = CTRL_ADDR
) (
  input  logic                     clk_usb,
  input  logic                     reset,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datao,
  input  logic                     reg_read,
  input  logic                     reg_write,
  output logic [7:0]               reg_datai,
  output logic                     fast_fifo_read,
  output logic                     fifo_rd_en,
  input  logic [31:0]              fifo_dout,
  input  logic                     fifo_empty,
  output logic                     underflow
);

  logic        enable;
  logic        inflight;
  logic        reg_read_r;
  logic        ctrl_write;
  logic        flush;
  logic        pop;
  logic        push;
  logic        issue;
  logic        pop_empty;
  logic [31:0] head;
  logic [1:0]  count;
  logic [7:0]  head_byte;
  logic [7:0]  datai_next;
  logic        unused_bits;

  assign unused_bits = ^{reg_bytecnt[pBYTECNT_SIZE-1:2], reg_datao[7:2]};

  assign ctrl_write = reg_write & (reg_address == pCTRL_ADDR);
  assign flush      = ctrl_write & reg_datao[CTRL_FLUSH_BIT];
  // A word is consumed when the host finishes reading its last byte.
  assign pop        = reg_read_r & ~reg_read & (reg_address == pFIFO_ADDR) &
                      (reg_bytecnt[1:0] == 2'd3);
  assign push       = inflight & ~flush;
  assign issue      = enable & ~fifo_empty & ~inflight & (count < 2'd2) & ~flush & ~reset;

  assign fifo_rd_en     = issue;
  assign fast_fifo_read = enable;

  usb_fifo_byte_reader_prefetch_buf u_buf (
    .clk       (clk_usb),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .pop_empty (pop_empty)
  );

  // Control state, read-strobe history, fetch tracking and sticky underflow.
  always_ff @(posedge clk_usb) begin
    if (reset) begin
      enable     <= 1'b0;
      inflight   <= 1'b0;
      reg_read_r <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      reg_read_r <= reg_read;
      inflight   <= issue;
      if (ctrl_write) enable <= reg_datao[CTRL_ENABLE_BIT];
      else            enable <= enable;
      if (flush)          underflow <= 1'b0;
      else if (pop_empty) underflow <= 1'b1;
      else                underflow <= underflow;
    end
  end

  // Read-data mux: head-word byte lane, status byte, or zero.
  always_comb begin
    head_byte  = 8'h00;
    datai_next = 8'h00;
    case (reg_bytecnt[1:0])
      2'd0:    head_byte = head[7:0];
      2'd1:    head_byte = head[15:8];
      2'd2:    head_byte = head[23:16];
      default: head_byte = head[31:24];
    endcase
    if (reg_address == pFIFO_ADDR) begin
      if (count == 2'd0) datai_next = UNDERFLOW_FILL;
      else               datai_next = head_byte;
    end else if (reg_address == pCTRL_ADDR) begin
      datai_next = status_byte(underflow, count, enable);
    end else begin
      datai_next = 8'h00;
    end
  end

  // Registered read data for the front end's one-clock read contract.
  always_ff @(posedge clk_usb) begin
    if (reset) reg_datai <= 8'h00;
    else       reg_datai <= datai_next;
  end

endmodule

// File: tb/tb_usb_fifo_byte_reader.sv
// Self-checking bench: directed scenarios plus random traffic against a
// word-stream reference model of the byte reader.
module tb_usb_fifo_byte_reader;

  localparam logic [7:0] A_FIFO = 8'd3;
  localparam logic [7:0] A_CTRL = 8'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  reg_address = 8'd0;
  logic [6:0]  reg_bytecnt = 7'd0;
  logic [7:0]  reg_datao = 8'd0;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic [7:0]  reg_datai;
  logic        fast_fifo_read;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout = 32'h0;
  logic        fifo_empty;
  logic        underflow;

  always #5 clk = ~clk;

  usb_fifo_byte_reader dut (
    .clk_usb        (clk),
    .reset          (reset),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datao      (reg_datao),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_datai      (reg_datai),
    .fast_fifo_read (fast_fifo_read),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_dout      (fifo_dout),
    .fifo_empty     (fifo_empty),
    .underflow      (underflow)
  );

  // Capture-FIFO environment: standard read, data one clock after rd_en.
  logic [31:0] src_mem [0:511];
  int src_wr = 0;
  int src_rd = 0;
  int rd_pulses = 0;
  int rd_empty_err = 0;
  assign fifo_empty = (src_rd == src_wr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_pulses <= rd_pulses + 1;
      if (src_rd == src_wr) rd_empty_err <= rd_empty_err + 1;
      else begin
        fifo_dout <= src_mem[src_rd];
        src_rd    <= src_rd + 1;
      end
    end
  end

  // Reference model: stream index of head word, sticky underflow, enable.
  int checks = 0;
  int failures = 0;
  int base = 0;
  logic uf_exp = 1'b0;
  logic en_exp = 1'b0;
  int bc_cur = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mcount();
    int a;
    a = src_wr - base;
    return (a > 2) ? 2 : a;
  endfunction

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic push_src(input logic [31:0] w);
    src_mem[src_wr] = w;
    src_wr++;
  endtask

  task automatic ctrl_wr(input logic [7:0] v);
    @(negedge clk);
    reg_address = A_CTRL;
    reg_datao   = v;
    reg_write   = 1'b1;
    @(negedge clk);
    reg_write = 1'b0;
    if (v[1]) begin
      base   = base + mcount();
      uf_exp = 1'b0;
    end
    en_exp = v[0];
    settle();
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [6:0] bc, output logic [7:0] data);
    @(negedge clk);
    reg_address = addr;
    reg_bytecnt = bc;
    reg_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data     = reg_datai;
    reg_read = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic fifo_byte(input int bc, output logic [7:0] got);
    logic [31:0] w;
    logic [7:0]  exp;
    int lane;
    lane = bc % 4;
    if (mcount() == 0) exp = 8'hEE;
    else begin
      w   = src_mem[base];
      exp = w[8*lane +: 8];
    end
    bus_read(A_FIFO, 7'(bc), got);
    check_eq("fifo_byte", 32'(got), 32'(exp));
    if (lane == 3) begin
      if (mcount() > 0) base++;
      else              uf_exp = 1'b1;
    end
  endtask

  task automatic check_state();
    logic [7:0] d;
    logic [1:0] c;
    c = 2'(mcount());
    bus_read(A_CTRL, 7'd0, d);
    check_eq("status", 32'(d), 32'({4'b0000, uf_exp, c, en_exp}));
    check_eq("underflow", 32'(underflow), 32'(uf_exp));
    check_eq("fast_fifo_read", 32'(fast_fifo_read), 32'(en_exp));
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] cst;
    bit found;
    int r;
    int n;

    // 1: reset values, enable, two prefetches
    repeat (3) @(negedge clk);
    check_eq("rst_datai", 32'(reg_datai), 32'h0);
    check_eq("rst_fast", 32'(fast_fifo_read), 32'h0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    check_eq("rst_underflow", 32'(underflow), 32'h0);
    reset = 1'b0;
    bus_read(A_CTRL, 7'd0, d);
    check_eq("rst_status", 32'(d), 32'h0);
    push_src(32'h44332211);
    push_src(32'h88776655);
    ctrl_wr(8'h01);
    check_eq("t1_fast", 32'(fast_fifo_read), 32'h1);
    check_eq("t1_rd_pulses", 32'(rd_pulses), 32'd2);
    bus_read(A_CTRL, 7'd0, d);
    check_eq("t1_status", 32'(d), 32'h05);

    // 2: eight byte reads with refill behind them
    push_src(32'hCCBBAA99);
    push_src(32'h00FFEEDD);
    settle();
    for (int i = 0; i < 8; i++) begin
      fifo_byte(i, d);
      cst = 8'(8'h11 * (i + 1));
      check_eq("t2_const", 32'(d), 32'(cst));
    end
    check_state();

    // 4: byte-3 pop coinciding with an in-flight fill at count 1
    push_src(32'h5A5A0505);
    push_src(32'h6B6B0606);
    settle();
    @(negedge clk);
    reg_address = A_FIFO;
    reg_bytecnt = 7'd3;
    reg_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("t4_byte3", 32'(reg_datai), 32'h000000CC);
    reg_read = 1'b0;
    base++;
    @(negedge clk);
    check_eq("t4_rd_en", 32'(fifo_rd_en), 32'h1);
    reg_read = 1'b1;
    @(negedge clk);
    reg_read = 1'b0;
    base++;
    @(negedge clk);
    reg_address = A_CTRL;
    @(negedge clk);
    check_eq("t4_status_cnt1", 32'(reg_datai), 32'h03);
    settle();
    check_state();
    for (int i = 0; i < 4; i++) fifo_byte(i, d);

    // 5: reset one cycle after a fetch request drops buffer and in-flight word
    push_src(32'h77770007);
    push_src(32'h88880008);
    push_src(32'h99990009);
    settle();
    @(negedge clk);
    reg_address = A_FIFO;
    reg_bytecnt = 7'd3;
    reg_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reg_read = 1'b0;
    base++;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (fifo_rd_en) found = 1'b1;
    end
    check_eq("t5_rd_en_seen", 32'(found), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    base  = base + 2;
    en_exp = 1'b0;
    uf_exp = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_fast", 32'(fast_fifo_read), 32'h0);
    check_eq("t5_rd_en", 32'(fifo_rd_en), 32'h0);
    reset = 1'b0;
    bus_read(A_CTRL, 7'd0, d);
    check_eq("t5_status", 32'(d), 32'h00);
    ctrl_wr(8'h01);
    check_state();

    // 6: bytecnt roll-over 127 -> 0 mid-stream
    push_src(32'hA1B2C3D4);
    settle();
    for (int i = 0; i < 12; i++) fifo_byte((124 + i) % 128, d);
    check_state();

    // random traffic
    bc_cur = 0;
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) if (src_wr < 500) push_src($urandom);
        settle();
      end else if (r <= 7) begin
        n = $urandom_range(1, 8);
        for (int k = 0; k < n; k++) begin
          fifo_byte(bc_cur, d);
          bc_cur = (bc_cur + 1) % 128;
        end
      end else if (r == 8) begin
        check_state();
      end else begin
        ctrl_wr(8'h03);
        check_state();
      end
    end

    // 3: drain, then underflow on an empty buffer and clear by flush
    for (int g = 0; g < 600 && (src_wr - base) > 0; g++) begin
      fifo_byte(bc_cur, d);
      bc_cur = (bc_cur + 1) % 128;
    end
    for (int i = 0; i < 4; i++) begin
      fifo_byte(i, d);
      check_eq("t3_fill", 32'(d), 32'h000000EE);
    end
    check_eq("t3_underflow", 32'(underflow), 32'h1);
    bus_read(A_CTRL, 7'd0, d);
    check_eq("t3_status", 32'(d), 32'h09);
    check_state();
    ctrl_wr(8'h03);
    bus_read(A_CTRL, 7'd0, d);
    check_eq("t3_status_clr", 32'(d), 32'h01);
    check_state();

    check_eq("rd_en_while_empty", 32'(rd_empty_err), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
